alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU (operands a/b, 3-bit op, 8-bit result) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Registers the winning operands, drives the ALU for one cycle, then returns the registered result with the requester ID over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU itself stays external.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- OP_W, 3, ALU opcode width; the opcode is passed through without decoding.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_i  in  NUM_REQ*DATA_W  packed operand A; requester k occupies slice k.
- req_b_i  in  NUM_REQ*DATA_W  packed operand B.
- req_op_i  in  NUM_REQ*OP_W  packed opcode.
- alu_a_o  out  DATA_W  operand A to the ALU.
- alu_b_o  out  DATA_W  operand B to the ALU.
- alu_op_o  out  OP_W  opcode to the ALU.
- alu_res_i  in  DATA_W  combinational ALU result.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept from the consumer.
- rsp_data_o  out  DATA_W  registered result.
- rsp_id_o  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- done_cnt_o  out  CNT_W  count of completed responses; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All outputs 0.
  - Captured operand/op/id registers 0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - done_cnt_o = 0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first requester with req_valid_i set, searching from (ptr+1) mod NUM_REQ upward and wrapping.
  - req_ready_o[g] = 1 combinationally, in IDLE only; all other bits 0.
  - No valid requesters: req_ready_o = 0 and state stays IDLE.
  - On a clock edge with valid&ready: capture slice g of a/b/op and id = g; ptr <= g; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a_o/alu_b_o/alu_op_o are always driven from the captured registers, so they are stable from EXEC onward.
  - At the end of EXEC: rsp_data_o <= alu_res_i, rsp_id_o <= id, rsp_valid_o <= 1; go to RESP.
- RESP:
  - rsp_valid_o, rsp_data_o and rsp_id_o are held stable until rsp_ready_i = 1 is sampled.
  - On handshake: rsp_valid_o <= 0, done_cnt_o <= done_cnt_o+1 (wraps to 0 at all-ones), go to IDLE.
  - req_ready_o = 0 throughout.
- Latency and throughput:
  - Acceptance in cycle c → EXEC in c+1 → rsp_valid_o high in c+2.
  - Best-case throughput is one operation every 3 cycles (no request/response overlap).
- Requester rules:
  - Hold valid and payload stable until ready.
  - A valid dropped before grant is simply not considered.
  - A payload change while ungranted has no effect.
- Simultaneous requests: exactly one grant per IDLE cycle; losers keep waiting.
  - Fairness: with continuous requests, no requester waits more than NUM_REQ-1 grants.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is produced, and outputs drop to 0 immediately.

Decomposition:
- Package alu_share_pkg:
  - state typedef enum {IDLE, EXEC, RESP}.
  - Default parameter constants.
  - Opcode constant OP_ADD = 3'b000, used by the bench.
- Sub-module rr_pick: purely combinational.
  - Inputs: NUM_REQ-bit request vector and last-grant pointer.
  - Outputs: one-hot grant, grant index, any_valid.

Test Plan:
- Single request:
  - Stimulus: req0 valid, a=8'd10, b=8'd20, op=000, rsp_ready=1, ALU instance connected.
  - Response: req_ready_o=0001 in the same cycle; alu_a_o=10, alu_b_o=20 in the next cycle; rsp_valid_o one cycle later with rsp_data_o=30, rsp_id_o=0; done_cnt_o=1.
- All four requesters valid from reset, rsp_ready held 1:
  - Grants in order 0,1,2,3, spaced 3 cycles apart.
  - rsp_id_o follows 0,1,2,3.
  - done_cnt_o=4.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid/data/id held constant and req_ready_o=0 throughout.
  - On release, state returns to IDLE and the next grant is issued one cycle later.
- Fairness: req0 and req2 held valid continuously.
  - Grant sequence 0,2,0,2,…
  - req1 and req3 are never granted.
- Reset asserted mid-EXEC:
  - Outputs 0 asynchronously and no response is produced.
  - After release with req3 and req0 valid, req0 is granted first.
- Counter wrap, with CNT_W=4: after 16 completed responses done_cnt_o reads 0, and after 17 it reads 1.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and defaults for the ALU-sharing arbiter: FSM state encoding,
// default parameter values and the opcode the bench uses for addition.
package alu_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_OP_W    = 3;
  localparam int DEF_CNT_W   = 16;

  localparam logic [2:0] OP_ADD = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester-index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle between the requesters/ALU/consumer (master)
// and the arbiter (slave).
interface alu_share_arbiter_if
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_a_i;
  logic [NUM_REQ*DATA_W-1:0] req_b_i;
  logic [NUM_REQ*OP_W-1:0]   req_op_i;
  logic [DATA_W-1:0]         alu_a_o;
  logic [DATA_W-1:0]         alu_b_o;
  logic [OP_W-1:0]           alu_op_o;
  logic [DATA_W-1:0]         alu_res_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [DATA_W-1:0]         rsp_data_o;
  logic [ID_W-1:0]           rsp_id_o;
  logic [CNT_W-1:0]          done_cnt_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_op_i, alu_res_i, rsp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_op_o,
    output rsp_valid_o, rsp_data_o, rsp_id_o, done_cnt_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_op_i, alu_res_i, rsp_ready_i,
    input  req_ready_o, alu_a_o, alu_b_o, alu_op_o,
    input  rsp_valid_o, rsp_data_o, rsp_id_o, done_cnt_o
  );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// last-grant pointer, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin : p_pick
    int idx;
    o_idx = '0;
    o_any = 1'b0;
    // Walk the search order backwards so the earliest candidate overwrites last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[idx]) begin
        o_idx = ID_W'(idx);
        o_any = 1'b1;
      end
    end
  end

  assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin front end for one shared combinational ALU: accept one request,
// present its registered operands for a cycle, then hold the result until taken.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic [CNT_W-1:0]  r_done;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  logic               w_accept;
  logic [DATA_W-1:0]  w_sel_a  [NUM_REQ];
  logic [DATA_W-1:0]  w_sel_b  [NUM_REQ];
  logic [OP_W-1:0]    w_sel_op [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_sel_a[gi]  = bus.req_a_i[gi*DATA_W +: DATA_W];
    assign w_sel_b[gi]  = bus.req_b_i[gi*DATA_W +: DATA_W];
    assign w_sel_op[gi] = bus.req_op_i[gi*OP_W +: OP_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (bus.req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == S_IDLE) && w_any;

  // Gated by reset as well so every output reads 0 while reset is held.
  assign bus.req_ready_o = ((r_state == S_IDLE) && !reset) ? w_grant_oh : '0;
  assign bus.alu_a_o     = r_a;
  assign bus.alu_b_o     = r_b;
  assign bus.alu_op_o    = r_op;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.rsp_id_o    = r_rsp_id;
  assign bus.done_cnt_o  = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_done      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a[w_grant_idx];
            r_b     <= w_sel_b[w_grant_idx];
            r_op    <= w_sel_op[w_grant_idx];
            r_id    <= w_grant_idx;
            r_ptr   <= w_grant_idx;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= bus.alu_res_i;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_done      <= r_done + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
